// File: rtl/exu_pc_ctrl.sv
// Architectural PC owner for a multi-cycle core: issues PCs to the IFU, accepts commits
// from the EXU, computes the next PC, flags misaligned targets and counts retirements.
module exu_pc_ctrl #(
    parameter int                   ISA_WIDTH    = 32,
    parameter logic [ISA_WIDTH-1:0] RESET_VECTOR = ISA_WIDTH'(32'h8000_0000),
    parameter int                   ALIGN_BITS   = 2,
    parameter int                   CNT_WIDTH    = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic [ISA_WIDTH-1:0] pc_out,
    output logic                 pc_valid,
    input  logic                 pc_ready,
    input  logic                 cmt_valid,
    output logic                 cmt_ready,
    input  logic [2:0]           cmt_kind,
    input  logic                 cmt_taken,
    input  logic [ISA_WIDTH-1:0] cmt_imm,
    input  logic [ISA_WIDTH-1:0] cmt_src1,
    input  logic                 cmt_ilen,
    input  logic [ISA_WIDTH-1:0] mtvec,
    input  logic [ISA_WIDTH-1:0] mepc,
    output logic                 misalign,
    output logic [ISA_WIDTH-1:0] misalign_addr,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] retired_cnt
);

    typedef enum logic [1:0] {S_ISSUE, S_EXEC, S_HALT} state_t;

    localparam logic [2:0] K_JAL    = 3'd1;
    localparam logic [2:0] K_JALR   = 3'd2;
    localparam logic [2:0] K_BRANCH = 3'd3;
    localparam logic [2:0] K_TRAP   = 3'd4;
    localparam logic [2:0] K_MRET   = 3'd5;
    localparam logic [2:0] K_HALT   = 3'd6;

    localparam logic [ISA_WIDTH-1:0] ALIGN_MASK = ISA_WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);

    state_t                 state_q, state_d;
    logic [ISA_WIDTH-1:0]   pc_q, pc_d;
    logic                   pc_valid_q, pc_valid_d;
    logic                   cmt_ready_q, cmt_ready_d;
    logic                   misalign_q, misalign_d;
    logic [ISA_WIDTH-1:0]   misalign_addr_q, misalign_addr_d;
    logic                   halted_q, halted_d;
    logic [CNT_WIDTH-1:0]   retired_q, retired_d;

    logic [ISA_WIDTH-1:0]   inc, seq_pc, rel_pc, trap_vec, target;
    logic                   check_align, target_bad;

    always_comb begin
        inc      = (ALIGN_BITS == 1 && cmt_ilen) ? ISA_WIDTH'(2) : ISA_WIDTH'(4);
        seq_pc   = pc_q + inc;
        rel_pc   = pc_q + cmt_imm;
        trap_vec = mtvec & ~ISA_WIDTH'(3);

        target      = seq_pc;
        check_align = 1'b0;
        case (cmt_kind)
            K_JAL: begin
                target      = rel_pc;
                check_align = 1'b1;
            end
            K_JALR: begin
                target      = (cmt_src1 + cmt_imm) & ~ISA_WIDTH'(1);
                check_align = 1'b1;
            end
            K_BRANCH: begin
                target      = cmt_taken ? rel_pc : seq_pc;
                check_align = cmt_taken;
            end
            K_TRAP:  target = trap_vec;
            K_MRET:  target = mepc & ~ALIGN_MASK;
            K_HALT:  target = pc_q;
            default: target = seq_pc;
        endcase
        target_bad = check_align && ((target & ALIGN_MASK) != '0);

        state_d         = state_q;
        pc_d            = pc_q;
        pc_valid_d      = pc_valid_q;
        cmt_ready_d     = cmt_ready_q;
        misalign_d      = 1'b0;
        misalign_addr_d = misalign_addr_q;
        halted_d        = halted_q;
        retired_d       = retired_q;

        case (state_q)
            S_ISSUE: begin
                if (pc_ready) begin
                    state_d     = S_EXEC;
                    pc_valid_d  = 1'b0;
                    cmt_ready_d = 1'b1;
                end
            end
            S_EXEC: begin
                if (cmt_valid) begin
                    retired_d   = retired_q + CNT_WIDTH'(1);
                    cmt_ready_d = 1'b0;
                    if (cmt_kind == K_HALT) begin
                        state_d  = S_HALT;
                        halted_d = 1'b1;
                    end else begin
                        state_d    = S_ISSUE;
                        pc_valid_d = 1'b1;
                        // A misaligned control-flow target diverts to the trap vector.
                        if (target_bad) begin
                            pc_d            = trap_vec;
                            misalign_d      = 1'b1;
                            misalign_addr_d = target;
                        end else begin
                            pc_d = target;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= S_ISSUE;
            pc_q            <= RESET_VECTOR;
            pc_valid_q      <= 1'b1;
            cmt_ready_q     <= 1'b0;
            misalign_q      <= 1'b0;
            misalign_addr_q <= '0;
            halted_q        <= 1'b0;
            retired_q       <= '0;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            pc_valid_q      <= pc_valid_d;
            cmt_ready_q     <= cmt_ready_d;
            misalign_q      <= misalign_d;
            misalign_addr_q <= misalign_addr_d;
            halted_q        <= halted_d;
            retired_q       <= retired_d;
        end
    end

    assign pc_out        = pc_q;
    assign pc_valid      = pc_valid_q;
    assign cmt_ready     = cmt_ready_q;
    assign misalign      = misalign_q;
    assign misalign_addr = misalign_addr_q;
    assign halted        = halted_q;
    assign retired_cnt   = retired_q;

endmodule
